// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle arbiter: FSM state encoding,
// datapath mux select patterns, ALU operation codes and operation modes.
package mc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        OP_B   = 3'd2,
        OP_C   = 3'd3,
        OP_D   = 3'd4,
        FINISH = 3'd5
    } state_t;

    // Mux select patterns, packed as {s0, s1, s2}
    localparam logic [2:0] SEL_IDLE   = 3'b000;
    localparam logic [2:0] SEL_LOAD_A = 3'b000;
    localparam logic [2:0] SEL_OP_B   = 3'b100;
    localparam logic [2:0] SEL_OP_C   = 3'b110;
    localparam logic [2:0] SEL_OP_D   = 3'b101;
    localparam logic [2:0] SEL_FINISH = 3'b000;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

    // MODE_ABCmD computes A+B+C-D, MODE_AmBCD computes A-B+C+D
    localparam logic MODE_ABCmD = 1'b0;
    localparam logic MODE_AmBCD = 1'b1;

    // ALU operation for a given step of the sequence under the latched mode.
    // Only OP_B and OP_D depend on the mode; everything else adds.
    function automatic logic alu_op(input state_t st, input logic mode);
        logic op;
        op = ADD;
        case (st)
            OP_B:    op = (mode == MODE_ABCmD) ? ADD : SUB;
            OP_D:    op = (mode == MODE_ABCmD) ? SUB : ADD;
            default: op = ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner selection. Picks the requester not served last when round
// robin is enabled, otherwise requester 0 wins any tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    input  logic       rr_en,
    output logic       win_valid,
    output logic       win_id
);

    // Choose a winner among the active requests
    always_comb begin
        win_valid = |req;
        win_id    = 1'b0;
        if (req == 2'b11) begin
            win_id = rr_en ? ~last_served : 1'b0;
        end else if (req == 2'b10) begin
            win_id = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_arbiter.sv
// Arbitrates two requesters onto a shared accumulate datapath and sequences
// the five-step A/B/C/D operation for the granted owner. All outputs are Moore
// outputs decoded from the state register and the latched owner and mode.
module multicycle_arbiter
    import mc_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic mode0,
    input  logic mode1,
    output logic gnt0,
    output logic gnt1,
    output logic busy,
    output logic e,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic addOrSub,
    output logic done0,
    output logic done1
);

    state_t     state;
    state_t     next_state;
    logic       owner;
    logic       owner_mode;
    logic       last_served;
    logic [1:0] arb_req;
    logic       win_valid;
    logic       win_id;
    logic       grant;

    // Requests presented to the arbiter: only in IDLE or FINISH, and in FINISH
    // the finishing owner's request is masked since it is still held high
    always_comb begin
        arb_req = 2'b00;
        if (state == IDLE) begin
            arb_req = {req1, req0};
        end else if (state == FINISH) begin
            arb_req = {req1 & ~owner, req0 & owner};
        end
    end

    rr_arb2 u_arb (
        .req         (arb_req),
        .last_served (last_served),
        .rr_en       (RR_EN),
        .win_valid   (win_valid),
        .win_id      (win_id)
    );

    assign grant = win_valid;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fixed walk through the steps, re-arbitrate at the end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = grant ? LOAD_A : IDLE;
            LOAD_A:  next_state = OP_B;
            OP_B:    next_state = OP_C;
            OP_C:    next_state = OP_D;
            OP_D:    next_state = FINISH;
            FINISH:  next_state = grant ? LOAD_A : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Owner, mode and fairness history, captured on the edge that grants
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner       <= 1'b0;
            owner_mode  <= MODE_ABCmD;
            last_served <= 1'b1;
        end else if (grant) begin
            owner       <= win_id;
            owner_mode  <= win_id ? mode1 : mode0;
            last_served <= win_id;
        end
    end

    // Output decode from state plus latched owner and mode
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        busy         = 1'b0;
        e            = 1'b0;
        {s0, s1, s2} = SEL_IDLE;
        addOrSub     = alu_op(state, owner_mode);
        done0        = 1'b0;
        done1        = 1'b0;
        case (state)
            IDLE: begin
                {s0, s1, s2} = SEL_IDLE;
            end
            LOAD_A: begin
                busy         = 1'b1;
                e            = 1'b1;
                {s0, s1, s2} = SEL_LOAD_A;
            end
            OP_B: begin
                busy         = 1'b1;
                e            = 1'b1;
                {s0, s1, s2} = SEL_OP_B;
            end
            OP_C: begin
                busy         = 1'b1;
                e            = 1'b1;
                {s0, s1, s2} = SEL_OP_C;
            end
            OP_D: begin
                busy         = 1'b1;
                e            = 1'b1;
                {s0, s1, s2} = SEL_OP_D;
            end
            FINISH: begin
                busy         = 1'b1;
                {s0, s1, s2} = SEL_FINISH;
                done0        = ~owner;
                done1        = owner;
            end
            default: begin
                {s0, s1, s2} = SEL_IDLE;
            end
        endcase
        if (state != IDLE) begin
            gnt0 = ~owner;
            gnt1 = owner;
        end
    end

endmodule

// File: tb/tb_multicycle_arbiter.sv
// Testbench for multicycle_arbiter. Two instances run side by side: index 0
// uses round-robin arbitration, index 1 uses fixed priority. A step-counter
// reference model predicts every output each cycle.
module tb_multicycle_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] req0_v, req1_v, mode0_v, mode1_v;
    logic [1:0] gnt0_v, gnt1_v, busy_v, e_v, s0_v, s1_v, s2_v, aos_v, done0_v, done1_v;

    int errors = 0;
    int checks = 0;

    // Reference model: phase -1 = idle, 0..4 = the five sequence steps
    int phase [2];
    bit own   [2];
    bit md    [2];
    bit last  [2];
    bit rr_cfg[2];

    localparam logic [9:0] RESET_VEC = 10'b0000000100;

    multicycle_arbiter #(.RR_EN(1'b1)) u_rr (
        .clock(clock), .reset(reset),
        .req0(req0_v[0]), .req1(req1_v[0]), .mode0(mode0_v[0]), .mode1(mode1_v[0]),
        .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]), .busy(busy_v[0]), .e(e_v[0]),
        .s0(s0_v[0]), .s1(s1_v[0]), .s2(s2_v[0]), .addOrSub(aos_v[0]),
        .done0(done0_v[0]), .done1(done1_v[0])
    );

    multicycle_arbiter #(.RR_EN(1'b0)) u_fp (
        .clock(clock), .reset(reset),
        .req0(req0_v[1]), .req1(req1_v[1]), .mode0(mode0_v[1]), .mode1(mode1_v[1]),
        .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]), .busy(busy_v[1]), .e(e_v[1]),
        .s0(s0_v[1]), .s1(s1_v[1]), .s2(s2_v[1]), .addOrSub(aos_v[1]),
        .done0(done0_v[1]), .done1(done1_v[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Structural invariants on both instances every cycle
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ((gnt0_v[i] && gnt1_v[i]) || (e_v[i] && !busy_v[i]) ||
                (done0_v[i] && !gnt0_v[i]) || (done1_v[i] && !gnt1_v[i])) begin
                errors++;
                $display("[TB] FAIL invariant dut%0d: gnt=%b%b e=%b busy=%b done=%b%b",
                         i, gnt0_v[i], gnt1_v[i], e_v[i], busy_v[i], done0_v[i], done1_v[i]);
            end
        end
    end

    function automatic logic [2:0] sel_of(input int p);
        case (p)
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic aos_of(input bit m, input int p);
        logic [4:0] tab;
        tab = m ? 5'b10111 : 5'b11101;
        return tab[4 - p];
    endfunction

    // Expected {gnt0,gnt1,busy,e,s0,s1,s2,addOrSub,done0,done1}
    function automatic logic [9:0] expv(input int i);
        logic [9:0] v;
        if (phase[i] < 0) return RESET_VEC;
        v[9:8] = own[i] ? 2'b01 : 2'b10;
        v[7]   = 1'b1;
        v[6]   = (phase[i] < 4);
        v[5:3] = sel_of(phase[i]);
        v[2]   = aos_of(md[i], phase[i]);
        v[1:0] = (phase[i] == 4) ? (own[i] ? 2'b01 : 2'b10) : 2'b00;
        return v;
    endfunction

    function automatic logic [9:0] obs(input int i);
        return {gnt0_v[i], gnt1_v[i], busy_v[i], e_v[i], s0_v[i], s1_v[i], s2_v[i],
                aos_v[i], done0_v[i], done1_v[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            phase[i] = -1;
            own[i]   = 1'b0;
            md[i]    = 1'b0;
            last[i]  = 1'b1;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge(input int i);
        bit c0, c1, w;
        if (!reset) begin
            phase[i] = -1;
            own[i]   = 1'b0;
            md[i]    = 1'b0;
            last[i]  = 1'b1;
        end else if (phase[i] == -1 || phase[i] == 4) begin
            c0 = req0_v[i] && !(phase[i] == 4 && own[i] == 1'b0);
            c1 = req1_v[i] && !(phase[i] == 4 && own[i] == 1'b1);
            if (c0 || c1) begin
                w        = (c0 && c1) ? (rr_cfg[i] ? !last[i] : 1'b0) : c1;
                own[i]   = w;
                md[i]    = w ? mode1_v[i] : mode0_v[i];
                last[i]  = w;
                phase[i] = 0;
            end else begin
                phase[i] = -1;
            end
        end else begin
            phase[i] = phase[i] + 1;
        end
    endtask

    // One clock cycle; a requester drops its request once it sees done
    task automatic tick();
        for (int i = 0; i < 2; i++) model_edge(i);
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (phase[i] == 4) begin
                if (own[i]) req1_v[i] = 1'b0;
                else        req0_v[i] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] m0, input logic [1:0] m1);
        req0_v  = r0;
        req1_v  = r1;
        mode0_v = m0;
        mode1_v = m1;
    endtask

    task automatic drain();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        for (int c = 0; c < 12 && (phase[0] != -1 || phase[1] != -1); c++) tick();
        checks++;
        if (phase[0] != -1 || phase[1] != -1) begin
            errors++;
            $display("[TB] FAIL drain: model still busy after bound");
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        tick();
        tick();
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== RESET_VEC) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: got %b want %b", i, obs(i), RESET_VEC);
            end
        end
        tick();
        tick();
        #2 reset = 1'b1;
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        applyStimulus(2'b11, 2'b11, 2'b00, 2'b11);
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL tie dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
                if (c == 1 || c == 6) begin
                    checks++;
                    if ({gnt0_v[i], gnt1_v[i], busy_v[i]} !== ((c == 1) ? 3'b101 : 3'b011)) begin
                        errors++;
                        $display("[TB] FAIL tie_handoff dut%0d cyc%0d: got gnt/busy %b%b%b", i, c,
                                 gnt0_v[i], gnt1_v[i], busy_v[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        drain();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00);
        for (int c = 1; c <= 7; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL single dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_mode1_toggle();
        logic [3:0] exp_aos;
        exp_aos = 4'b1011;
        drain();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) mode1_v = 2'b00;
            if (c == 4) mode1_v = 2'b11;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL mode1 dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
                if (c <= 4) begin
                    checks++;
                    if (aos_v[i] !== exp_aos[4 - c]) begin
                        errors++;
                        $display("[TB] FAIL mode1_aos dut%0d cyc%0d: got %b want %b", i, c,
                                 aos_v[i], exp_aos[4 - c]);
                    end
                end
            end
        end
    endtask

    task automatic test_dropped();
        drain();
        applyStimulus(2'b11, 2'b00, 2'b11, 2'b00);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req0_v = 2'b00;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL dropped dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00);
        for (int c = 1; c <= 3; c++) tick();
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== RESET_VEC) begin
                errors++;
                $display("[TB] FAIL reset_async dut%0d: got %b want %b", i, obs(i), RESET_VEC);
            end
        end
        model_reset();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b00);
        tick();
        tick();
        #2 reset = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL reset_mid dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
                if (c == 1) begin
                    checks++;
                    if (gnt1_v[i] !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL reset_regrant dut%0d: got gnt1=%b want 1", i, gnt1_v[i]);
                    end
                end
            end
        end
    endtask

    // Requester 0 served alone first, then a simultaneous tie from IDLE:
    // round robin hands it to 1, fixed priority to 0; both then held
    task automatic test_fixed_priority();
        drain();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00);
        for (int c = 0; c < 6; c++) tick();
        drain();
        applyStimulus(2'b11, 2'b11, 2'b01, 2'b10);
        for (int c = 1; c <= 24; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL priority dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
                if (c == 1) begin
                    checks++;
                    if (gnt1_v[i] !== (i == 0)) begin
                        errors++;
                        $display("[TB] FAIL priority_tie dut%0d: got gnt1=%b want %0d", i, gnt1_v[i], i == 0);
                    end
                end
                if (phase[i] != 4) begin
                    req0_v[i] = 1'b1;
                    req1_v[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic test_random();
        drain();
        for (int c = 1; c <= 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req0_v[i] && ($urandom_range(3) == 0)) req0_v[i] = 1'b1;
                if (!req1_v[i] && ($urandom_range(3) == 0)) req1_v[i] = 1'b1;
                if ($urandom_range(15) == 0) req0_v[i] = 1'b0;
                if ($urandom_range(15) == 0) req1_v[i] = 1'b0;
                mode0_v[i] = 1'($urandom_range(1));
                mode1_v[i] = 1'($urandom_range(1));
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("[TB] FAIL random dut%0d cyc%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        rr_cfg[0] = 1'b1;
        rr_cfg[1] = 1'b0;
        model_reset();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        #1;
        test_reset();
        test_tie_after_reset();
        test_single();
        test_mode1_toggle();
        test_dropped();
        test_reset_mid();
        test_fixed_priority();
        test_random();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
